// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA core sharing logic.
package rsa_pkg;

    localparam int RSA_W       = 256;
    localparam int TIMEOUT_DEF = 1048576;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_BUSY,
        S_DONE
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: first set bit of i_req scanning
// upward from i_ptr+1, wrapping modulo N; i_ptr itself has lowest priority.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    logic [IW:0] w_sum;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        for (int i = N; i >= 1; i--) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N))
                w_sum = w_sum - (IW+1)'(N);
            if (i_req[w_sum[IW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/rsa_core_arbiter.sv
// Round-robin sharing of one Rsa256Core among N_REQ requesters, with operand
// latching, result return to the owner and a watchdog against a hung core.
module rsa_core_arbiter
    import rsa_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int WIDTH          = RSA_W,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*WIDTH-1:0] i_a,
    input  logic [N_REQ*WIDTH-1:0] i_d,
    input  logic [N_REQ*WIDTH-1:0] i_n,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_err,
    output logic [WIDTH-1:0]       o_result,
    output logic                   o_busy,
    output logic                   o_core_start,
    output logic [WIDTH-1:0]       o_core_a,
    output logic [WIDTH-1:0]       o_core_d,
    output logic [WIDTH-1:0]       o_core_n,
    input  logic [WIDTH-1:0]       i_core_result,
    input  logic                   i_core_finished
);

    localparam int IW  = $clog2(N_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state, w_next;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic [N_REQ-1:0]   r_grant;
    logic               r_abandon;
    logic               r_timeout;
    logic [WDW-1:0]     r_wd;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_core_a, r_core_d, r_core_n;

    logic               w_pick_vld;
    logic [IW-1:0]      w_pick_idx;
    logic               w_wd_exp;
    logic               w_owner_req;

    rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    assign w_wd_exp    = (r_wd == WDW'(TIMEOUT_CYCLES - 1));
    assign w_owner_req = i_req[r_owner];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_pick_vld) w_next = S_LOAD;
            S_LOAD:  w_next = S_START;
            S_START: w_next = S_BUSY;
            S_BUSY:  if (i_core_finished || w_wd_exp) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= IW'(N_REQ - 1);
            r_owner   <= '0;
            r_grant   <= '0;
            r_abandon <= 1'b0;
            r_timeout <= 1'b0;
            r_wd      <= '0;
            r_result  <= '0;
            r_core_a  <= '0;
            r_core_d  <= '0;
            r_core_n  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_vld) begin
                        r_core_a  <= i_a[w_pick_idx*WIDTH +: WIDTH];
                        r_core_d  <= i_d[w_pick_idx*WIDTH +: WIDTH];
                        r_core_n  <= i_n[w_pick_idx*WIDTH +: WIDTH];
                        r_grant   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_ptr     <= w_pick_idx;
                        r_owner   <= w_pick_idx;
                        r_abandon <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!w_owner_req) r_abandon <= 1'b1;
                end
                S_START: begin
                    if (!w_owner_req) r_abandon <= 1'b1;
                    r_wd      <= '0;
                    r_timeout <= 1'b0;
                end
                S_BUSY: begin
                    if (!w_owner_req) r_abandon <= 1'b1;
                    r_wd <= r_wd + 1'b1;
                    // A finish coinciding with expiry is a good result, not an error.
                    if (i_core_finished) begin
                        r_result <= i_core_result;
                    end else if (w_wd_exp) begin
                        r_result  <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    // Abandoned jobs complete silently: no done or error pulse to anyone.
    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_core_start = (r_state == S_START);
        o_done       = '0;
        o_err        = 1'b0;
        if (r_state == S_DONE && !r_abandon) begin
            o_done = r_grant;
            o_err  = r_timeout;
        end
    end

    assign o_grant  = r_grant;
    assign o_result = r_result;
    assign o_core_a = r_core_a;
    assign o_core_d = r_core_d;
    assign o_core_n = r_core_n;

endmodule

// File: tb/tb_rsa_core_arbiter.sv
// Scoreboard bench for rsa_core_arbiter with a behavioural modexp core model.
module tb_rsa_core_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   i_req;
    logic [N*W-1:0] i_a, i_d, i_n;
    logic [N-1:0]   o_grant, o_done;
    logic           o_err, o_busy, o_core_start;
    logic [W-1:0]   o_result, o_core_a, o_core_d, o_core_n;
    logic [W-1:0]   core_res;
    logic           core_fin;

    always #5 clk = ~clk;

    rsa_core_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req           (i_req),
        .i_a             (i_a),
        .i_d             (i_d),
        .i_n             (i_n),
        .o_grant         (o_grant),
        .o_done          (o_done),
        .o_err           (o_err),
        .o_result        (o_result),
        .o_busy          (o_busy),
        .o_core_start    (o_core_start),
        .o_core_a        (o_core_a),
        .o_core_d        (o_core_d),
        .o_core_n        (o_core_n),
        .i_core_result   (core_res),
        .i_core_finished (core_fin)
    );

    typedef struct {
        int           id;
        logic [W-1:0] res;
        logic         err;
        int           lat;
        logic         abandon;
    } job_t;

    job_t         sb[$];
    job_t         cur;
    bit           job_active = 0;
    int           start_cyc = 0;
    int           cyc = 0;
    int           done_cnt = 0;
    int           jobs_left[N];
    int           core_lat = 40;
    bit           hang = 0;
    int           n_chk = 0;
    int           n_pass = 0;
    logic [W-1:0] a_v[N], d_v[N], n_v[N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] modexp(input logic [W-1:0] a, input logic [W-1:0] d,
                                            input logic [W-1:0] n);
        logic [63:0] r, b;
        r = 64'd1 % n;
        b = 64'(a) % n;
        for (int i = 0; i < W; i++) begin
            if (d[i]) r = (r * b) % n;
            b = (b * b) % n;
        end
        return r[W-1:0];
    endfunction

    task automatic push(input int id, input bit err, input int lat, input bit ab);
        job_t j;
        j.id      = id;
        j.err     = err;
        j.res     = err ? '0 : modexp(a_v[id], d_v[id], n_v[id]);
        j.lat     = lat;
        j.abandon = ab;
        sb.push_back(j);
    endtask

    // Core model: finished pulses core_lat cycles after the start cycle.
    logic [W-1:0] cnt, pend;
    bit           run;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 0;
            cnt      <= '0;
            pend     <= '0;
            core_fin <= 1'b0;
            core_res <= '0;
        end else begin
            core_fin <= 1'b0;
            core_res <= 16'hA5A5;
            if (o_core_start) begin
                run  <= 1;
                cnt  <= W'(core_lat - 1);
                pend <= modexp(o_core_a, o_core_d, o_core_n);
            end else if (hang) begin
                run <= 0;
            end else if (run) begin
                if (cnt == 1) begin
                    core_fin <= 1'b1;
                    core_res <= pend;
                    run      <= 0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) i_req[k] = (jobs_left[k] != 0);
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (o_core_start) begin
                if (sb.size() == 0) begin
                    check("start_unexpected", 0, 1);
                end else begin
                    cur        = sb.pop_front();
                    job_active = 1;
                    start_cyc  = cyc;
                    check("grant", o_grant, 64'(1) << cur.id);
                    check("core_a", o_core_a, a_v[cur.id]);
                    check("core_d", o_core_d, d_v[cur.id]);
                    check("core_n", o_core_n, n_v[cur.id]);
                end
            end
            if (o_done != 0 || o_err) begin
                done_cnt++;
                if (!job_active) begin
                    check("done_unexpected", 0, 1);
                end else begin
                    check("done", o_done, cur.abandon ? 64'(0) : 64'(1) << cur.id);
                    check("err", o_err, cur.err);
                    check("result", o_result, cur.res);
                    check("latency", cyc - start_cyc, cur.lat);
                    check("grant_hold", o_grant, 64'(1) << cur.id);
                    job_active = 0;
                end
                for (int k = 0; k < N; k++)
                    if (o_done[k] && jobs_left[k] > 0) jobs_left[k]--;
            end
        end
    end

    function automatic bit pending();
        bit p = o_busy || (sb.size() != 0);
        for (int k = 0; k < N; k++) if (jobs_left[k] != 0) p = 1;
        return p;
    endfunction

    task automatic wait_idle(input string tag, input int maxc);
        int c = 0;
        while (pending() && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_idle"}, c < maxc, 1);
    endtask

    task automatic wait_start(input string tag);
        int c = 0;
        while (!o_core_start && c < 50) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_start_seen"}, o_core_start, 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 0;
        sb.delete();
        job_active = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        int c, d0;
        for (int k = 0; k < N; k++) jobs_left[k] = 0;
        a_v = '{16'd5, 16'd4,   16'd7,  16'd3};
        d_v = '{16'd3, 16'd13,  16'd5,  16'd4};
        n_v = '{16'd7, 16'd497, 16'd11, 16'd10};
        for (int k = 0; k < N; k++) begin
            i_a[k*W +: W] = a_v[k];
            i_d[k*W +: W] = d_v[k];
            i_n[k*W +: W] = n_v[k];
        end
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        check("rst_grant", o_grant, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_result", o_result, 0);
        check("rst_core_a", o_core_a, 0);
        check("rst_start", o_core_start, 0);
        @(posedge clk);
        #1 rst_n = 1;

        // Single request, start two cycles after the sampling cycle
        @(posedge clk);
        #1;
        core_lat = 40;
        push(0, 0, 41, 0);
        jobs_left[0] = 1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!o_core_start && c < 10);
        check("start_latency", c - 1, 2);
        wait_idle("single", 200);

        // Simultaneous requests 1 and 2, twice
        do_reset();
        core_lat = 6;
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            #1;
            push(1, 0, 7, 0);
            push(2, 0, 7, 0);
            jobs_left[1] = 1;
            jobs_left[2] = 1;
            wait_idle("simul", 200);
        end

        // All four requesting for two rounds
        do_reset();
        core_lat = 5;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push(k, 0, 6, 0);
        for (int k = 0; k < N; k++) jobs_left[k] = 2;
        wait_idle("fair", 400);
        check("fair_done_count", done_cnt - d0, 8);

        // Requester 2 abandons during BUSY; requester 3 follows
        core_lat = 20;
        @(posedge clk);
        #1;
        push(2, 0, 21, 1);
        push(3, 0, 21, 0);
        jobs_left[2] = 1;
        jobs_left[3] = 1;
        wait_start("abandon");
        d0 = done_cnt;
        c  = 0;
        do begin
            @(negedge clk);
            c++;
            if (c == 5) jobs_left[2] = 0;
        end while (o_busy && c < 100);
        check("abandon_busy_fall", c, 22);
        check("abandon_no_done", done_cnt, d0);
        check("abandon_result", o_result, modexp(a_v[2], d_v[2], n_v[2]));
        wait_idle("abandon", 200);

        // Hung core: watchdog abort
        hang = 1;
        @(posedge clk);
        #1;
        push(0, 1, TO + 1, 0);
        jobs_left[0] = 1;
        wait_idle("timeout", 300);
        hang = 0;
        check("timeout_idle", o_busy, 0);

        // Asynchronous reset mid-BUSY, then requester 0 wins afresh
        core_lat = 20;
        @(posedge clk);
        #1;
        push(1, 0, 21, 0);
        jobs_left[1] = 1;
        wait_start("rstmid");
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("rstmid_grant", o_grant, 0);
        check("rstmid_busy", o_busy, 0);
        check("rstmid_start", o_core_start, 0);
        check("rstmid_done", o_done, 0);
        sb.delete();
        job_active = 0;
        jobs_left[0] = 1;
        push(0, 0, 21, 0);
        push(1, 0, 21, 0);
        @(negedge clk);
        rst_n = 1;
        wait_idle("rstmid", 300);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rsa_core_arbiter.md
Name: rsa_core_arbiter

Overview:
Shares one Rsa256Core among N_REQ independent requesters, such as several UART/Avalon wrappers or a self-test engine. Selects one requester by round-robin and latches its operands. Pulses the core start, waits for the core's finished flag, then returns the result to the owning requester. Provides a watchdog so a hung core cannot lock the resource.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 256, operand/result width in bits
TIMEOUT_CYCLES, 1048576, maximum BUSY cycles before the job is aborted with error

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_req  in  N_REQ  per-requester job request; level, held until o_done or abandoned
i_a  in  N_REQ*WIDTH  packed base operands; requester k uses [k*WIDTH +: WIDTH]
i_d  in  N_REQ*WIDTH  packed exponents
i_n  in  N_REQ*WIDTH  packed moduli
o_grant  out  N_REQ  one-hot owner of the core; all zero when idle
o_done  out  N_REQ  one-cycle pulse to the owner when its result is valid
o_err  out  1  one-cycle pulse, coincident with o_done, on watchdog abort
o_result  out  WIDTH  result register; valid while o_done is high
o_busy  out  1  high in any state other than IDLE
o_core_start  out  1  start pulse to the core
o_core_a  out  WIDTH  latched operand to the core
o_core_d  out  WIDTH  latched operand to the core
o_core_n  out  WIDTH  latched operand to the core
i_core_result  in  WIDTH  core output
i_core_finished  in  1  core completion pulse

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. All outputs zero. Operand and result registers zero. RR pointer = N_REQ-1, so requester 0 has first priority. Watchdog counter 0.
- State machine:
  - IDLE -> LOAD when any i_req is high.
  - LOAD -> START.
  - START -> BUSY.
  - BUSY -> DONE on i_core_finished or on watchdog expiry.
  - DONE -> IDLE.
- IDLE: the winner is the first asserted i_req scanning from pointer+1 upward, wrapping modulo N_REQ. On the transition edge:
  - latch the winner's a/d/n into the o_core_* registers;
  - set o_grant to one-hot(winner);
  - set pointer = winner.
- LOAD: one settle cycle. Operands are stable before start.
- START: o_core_start=1 for exactly this one cycle. Clear the watchdog.
- BUSY:
  - The watchdog increments each cycle.
  - If i_core_finished=1, capture i_core_result into o_result.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without finished, set o_result=0 and flag the error.
- DONE:
  - o_done[owner]=1 for one cycle; o_err=1 for one cycle if the job timed out.
  - o_grant is still held this cycle and clears on exit.
- Latency: i_req sampled in IDLE at cycle 0 -> o_core_start high in cycle 2. i_core_finished at cycle k -> o_done high at cycle k+1. The next arbitration decision is the cycle after DONE, so there are at least 2 cycles between consecutive jobs.
- Operands are sampled only at the IDLE->LOAD edge. Later changes on i_a/i_d/i_n are ignored until the next grant.
- Abandon rule: if the owner drops i_req in LOAD, START or BUSY, the job still runs to finished or timeout. The core has no abort. In DONE, o_done is suppressed (all zero), o_result is still updated, and o_err is suppressed.
- i_core_finished outside BUSY is ignored.
- Finished and watchdog expiry in the same cycle: finished wins, with no error.
- Requests that assert during the DONE cycle are considered in the following IDLE cycle. Fairness: with all requesters persistently asserting, grants rotate 0,1,...,N_REQ-1,0.
- Reset mid-job returns to IDLE immediately. The core must be reset by the same reset. No o_done is emitted.

Decomposition:
- Shared package rsa_pkg holds:
  - WIDTH as RSA_W=256;
  - the state enum {S_IDLE, S_LOAD, S_START, S_BUSY, S_DONE};
  - the default TIMEOUT_CYCLES constant.
- One sub-module, rr_picker: combinational round-robin priority encoder. Inputs are the req vector and the pointer; outputs are a valid flag and the winner index. It is reusable for the Avalon bus-sharing block.

Test Plan:
- Single request: i_req=0001, a=5, d=3, n=7; core model finishes 40 cycles after start with 6 -> o_core_start in cycle 2, o_done=0001 with o_result=6 at finish+1, o_err=0.
- Simultaneous requests: i_req=0110 from reset -> grant 0010 first, then 0100. Re-assert both -> grant 0010 then 0100 again, with no starvation.
- All four requesting continuously for 8 jobs -> grant order 0,1,2,3,0,1,2,3, exactly one o_done per job.
- Abandon: requester 2 drops i_req during BUSY -> no o_done pulse, o_busy falls after finished, then the next pending requester is served.
- Timeout: TIMEOUT_CYCLES=16, core never finishes -> o_done[owner] and o_err both pulse 17 cycles after start, o_result=0, arbiter back in IDLE.
- Reset mid-BUSY: assert i_rst_n=0 asynchronously -> o_grant, o_busy and o_core_start go to 0 immediately. After release, a pending request is granted afresh with requester 0 priority.
